// File: rtl/exe_fwd_scoreboard.sv
// exe_fwd_scoreboard -- operand forwarding and load-use hazard unit for EXE.
//
// A small tag pipeline shadows the stages after EXE (stage 1 = MEM ...
// stage NUM_STAGES = WB). Each tag carries {valid, rfwr, dst, ready_at}, where
// ready_at is the first stage whose result bus carries that instruction's
// result. For every EXE source operand the youngest matching producer is
// selected. If that producer's data is not on a bus yet, the operand is
// pending, and hazard_stall is raised when the operand is actually used.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset (reset wins over all)
//   src_addr       NUM_SRC packed source register numbers, operand i at [i*REG_AW +: REG_AW]
//   src_used       operand i is read by the EXE instruction
//   exe_valid      EXE holds a real instruction
//   exe_rfwr       EXE instruction writes the register file
//   exe_dst        EXE destination register
//   exe_ready_at   first stage with the EXE result; stored clamped to 1..NUM_STAGES
//   pipe_adv       the EXE..WB pipeline advances this cycle
//   flush_mask     bit k-1 kills the tag that sits in stage k after this edge
//   fwd_sel        per operand: 0 = register file, k = result bus of stage k
//   fwd_hit        per operand: a matching in-flight producer exists
//   hazard_stall   a used operand is waiting on data that is not ready
//   perf_stall_cnt, perf_fwd_cnt   only when FWD_PERF_CNT_EN is defined
//
// Build option: define FWD_PERF_CNT_EN to add the two 32-bit perf counters.

// Per-operand lookup: scan from the oldest stage to the youngest so that the
// last hit written wins. Older matches are shadowed by the younger ones.
module exe_fwd_lane #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int SW         = 2
) (
  input  logic [NUM_STAGES-1:0]             tag_valid,
  input  logic [NUM_STAGES-1:0]             tag_rfwr,
  input  logic [NUM_STAGES-1:0][REG_AW-1:0] tag_dst,
  input  logic [NUM_STAGES-1:0][SW-1:0]     tag_rdy,
  input  logic [REG_AW-1:0]                 src,
  output logic [SW-1:0]                     sel,
  output logic                              hit,
  output logic                              pending
);
  always_comb begin
    sel     = '0;
    hit     = 1'b0;
    pending = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      // r0 is hardwired zero: never a producer
      if (tag_valid[k-1] && tag_rfwr[k-1] &&
          (tag_dst[k-1] != '0) && (tag_dst[k-1] == src)) begin
        hit = 1'b1;
        if (tag_rdy[k-1] <= SW'(k)) begin
          sel     = SW'(k);
          pending = 1'b0;
        end else begin
          sel     = '0;
          pending = 1'b1;
        end
      end
    end
  end
endmodule

module exe_fwd_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int SW         = $clog2(NUM_STAGES+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic                      exe_valid,
  input  logic                      exe_rfwr,
  input  logic [REG_AW-1:0]         exe_dst,
  input  logic [SW-1:0]             exe_ready_at,
  input  logic                      pipe_adv,
  input  logic [NUM_STAGES-1:0]     flush_mask,
  output logic [NUM_SRC*SW-1:0]     fwd_sel,
  output logic [NUM_SRC-1:0]        fwd_hit,
`ifdef FWD_PERF_CNT_EN
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_fwd_cnt,
`endif
  output logic                      hazard_stall
);

  // index k-1 holds the tag for stage k
  logic [NUM_STAGES-1:0]             tag_valid;
  logic [NUM_STAGES-1:0]             tag_rfwr;
  logic [NUM_STAGES-1:0][REG_AW-1:0] tag_dst;
  logic [NUM_STAGES-1:0][SW-1:0]     tag_rdy;

  logic [NUM_STAGES-1:0]             valid_nxt;
  logic [SW-1:0]                     rdy_clamp;

  logic [NUM_SRC-1:0][SW-1:0]        lane_sel;
  logic [NUM_SRC-1:0]                lane_hit;
  logic [NUM_SRC-1:0]                lane_pend;

  // A ready stage of 0 would mean "ready in EXE" which this unit cannot
  // forward from, so it is treated as MEM; beyond WB is treated as WB.
  always_comb begin
    if (exe_ready_at == '0)
      rdy_clamp = SW'(1);
    else if (exe_ready_at > SW'(NUM_STAGES))
      rdy_clamp = SW'(NUM_STAGES);
    else
      rdy_clamp = exe_ready_at;
  end

  // Valid bits: shift on advance, then flush is applied to the post-shift
  // positions so the mask always names the stage the tag ends up in.
  always_comb begin
    valid_nxt = tag_valid;
    if (pipe_adv) begin
      for (int k = NUM_STAGES-1; k >= 1; k--)
        valid_nxt[k] = tag_valid[k-1];
      valid_nxt[0] = exe_valid;
    end
    valid_nxt = valid_nxt & ~flush_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      tag_rfwr  <= '0;
      tag_dst   <= '0;
      tag_rdy   <= '0;
    end else begin
      tag_valid <= valid_nxt;
      if (pipe_adv) begin
        for (int k = NUM_STAGES-1; k >= 1; k--) begin
          tag_rfwr[k] <= tag_rfwr[k-1];
          tag_dst[k]  <= tag_dst[k-1];
          tag_rdy[k]  <= tag_rdy[k-1];
        end
        tag_rfwr[0] <= exe_rfwr;
        tag_dst[0]  <= exe_dst;
        tag_rdy[0]  <= rdy_clamp;
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    exe_fwd_lane #(
      .NUM_STAGES(NUM_STAGES),
      .REG_AW    (REG_AW),
      .SW        (SW)
    ) u_lane (
      .tag_valid(tag_valid),
      .tag_rfwr (tag_rfwr),
      .tag_dst  (tag_dst),
      .tag_rdy  (tag_rdy),
      .src      (src_addr[i*REG_AW +: REG_AW]),
      .sel      (lane_sel[i]),
      .hit      (lane_hit[i]),
      .pending  (lane_pend[i])
    );
    assign fwd_sel[i*SW +: SW] = lane_sel[i];
    assign fwd_hit[i]          = lane_hit[i];
  end

  // An unused operand still reports its forwarding choice but never stalls.
  assign hazard_stall = |(lane_pend & src_used);

`ifdef FWD_PERF_CNT_EN
  logic [31:0] fwd_pop;

  always_comb begin
    fwd_pop = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if ((lane_sel[i] != '0) && src_used[i])
        fwd_pop = fwd_pop + 32'd1;
  end

  // Free-running, wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (hazard_stall)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (pipe_adv)
        perf_fwd_cnt <= perf_fwd_cnt + fwd_pop;
    end
  end
`endif

endmodule

// File: tb/tb_exe_fwd_scoreboard.sv
// Bench for exe_fwd_scoreboard (NUM_SRC=2, NUM_STAGES=3, REG_AW=5).
// The reference model keeps in-flight producers as a queue of records
// with an age (the stage they occupy); lookups pick the smallest age.
module tb_exe_fwd_scoreboard;
  localparam int NSRC = 2;
  localparam int NST  = 3;
  localparam int AW   = 5;
  localparam int SW   = 2;

  logic               clk;
  logic               rst;
  logic [NSRC*AW-1:0] src_addr;
  logic [NSRC-1:0]    src_used;
  logic               exe_valid;
  logic               exe_rfwr;
  logic [AW-1:0]      exe_dst;
  logic [SW-1:0]      exe_ready_at;
  logic               pipe_adv;
  logic [NST-1:0]     flush_mask;
  logic [NSRC*SW-1:0] fwd_sel;
  logic [NSRC-1:0]    fwd_hit;
  logic               hazard_stall;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]        perf_stall_cnt;
  logic [31:0]        perf_fwd_cnt;
`endif

  exe_fwd_scoreboard #(.NUM_SRC(NSRC), .NUM_STAGES(NST), .REG_AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_addr    (src_addr),
    .src_used    (src_used),
    .exe_valid   (exe_valid),
    .exe_rfwr    (exe_rfwr),
    .exe_dst     (exe_dst),
    .exe_ready_at(exe_ready_at),
    .pipe_adv    (pipe_adv),
    .flush_mask  (flush_mask),
    .fwd_sel     (fwd_sel),
    .fwd_hit     (fwd_hit),
`ifdef FWD_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_fwd_cnt  (perf_fwd_cnt),
`endif
    .hazard_stall(hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int age;   // stage currently occupied (1..NST)
    bit rfwr;
    int dst;
    int rdy;
  } ent_t;

  ent_t        m_q[$];
  logic [NSRC*SW-1:0] e_sel;
  logic [NSRC-1:0]    e_hit;
  logic               e_stall;
  logic [31:0]        pc_stall;
  logic [31:0]        pc_fwd;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic eval_model();
    e_sel   = '0;
    e_hit   = '0;
    e_stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      int best;
      int bi;
      int s;
      best = 99;
      bi   = -1;
      s    = int'(src_addr[i*AW +: AW]);
      foreach (m_q[j])
        if (m_q[j].rfwr && m_q[j].dst != 0 && m_q[j].dst == s && m_q[j].age < best) begin
          best = m_q[j].age;
          bi   = j;
        end
      if (bi >= 0) begin
        e_hit[i] = 1'b1;
        if (m_q[bi].rdy <= best) e_sel[i*SW +: SW] = SW'(best);
        else if (src_used[i])    e_stall = 1'b1;
      end
    end
  endtask

  task automatic model_tick();
    int r;
    if (rst) begin
      m_q.delete();
      pc_stall = '0;
      pc_fwd   = '0;
      return;
    end
    eval_model();
    if (e_stall) pc_stall = pc_stall + 1;
    if (pipe_adv)
      for (int i = 0; i < NSRC; i++)
        if (e_sel[i*SW +: SW] != 0 && src_used[i]) pc_fwd = pc_fwd + 1;
    if (pipe_adv) begin
      foreach (m_q[j]) m_q[j].age = m_q[j].age + 1;
      for (int j = m_q.size()-1; j >= 0; j--)
        if (m_q[j].age > NST) m_q.delete(j);
      if (exe_valid) begin
        r = int'(exe_ready_at);
        if (r < 1)   r = 1;
        if (r > NST) r = NST;
        m_q.push_front('{1, exe_rfwr, int'(exe_dst), r});
      end
    end
    for (int j = m_q.size()-1; j >= 0; j--)
      if (flush_mask[m_q[j].age-1]) m_q.delete(j);
  endtask

  // ---------------- cycle helpers ----------------
  task automatic settle();
    @(negedge clk);
    eval_model();
    chk("fwd_sel", 64'(fwd_sel), 64'(e_sel));
    chk("fwd_hit", 64'(fwd_hit), 64'(e_hit));
    chk("hazard_stall", 64'(hazard_stall), 64'(e_stall));
`ifdef FWD_PERF_CNT_EN
    chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(pc_stall));
    chk("perf_fwd_cnt", 64'(perf_fwd_cnt), 64'(pc_fwd));
`endif
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle();
    exe_valid  = 1'b0;
    exe_rfwr   = 1'b0;
    exe_dst    = '0;
    exe_ready_at = '0;
    pipe_adv   = 1'b0;
    flush_mask = '0;
  endtask

  task automatic push(input int dst, input int rdy, input bit rfwr);
    idle();
    exe_valid    = 1'b1;
    exe_rfwr     = rfwr;
    exe_dst      = AW'(dst);
    exe_ready_at = SW'(rdy);
    pipe_adv     = 1'b1;
    settle();
    edge_step();
  endtask

  task automatic drain();
    idle();
    pipe_adv = 1'b1;
    repeat (NST) begin settle(); edge_step(); end
    pipe_adv = 1'b0;
  endtask

  logic [31:0] stall_base;

  initial begin
    idle();
    rst      = 1'b1;
    src_addr = '0;
    src_used = '0;
    pc_stall = '0;
    pc_fwd   = '0;
    // tags are unknown before the first reset edge: no checks here
    edge_step();
    edge_step();

    // 1: reset state
    rst      = 1'b0;
    src_addr = {5'd3, 5'd3};
    src_used = 2'b11;
    settle();
    chk("t1_sel", 64'(fwd_sel), 64'd0);
    chk("t1_hit", 64'(fwd_hit), 64'd0);
    chk("t1_stall", 64'(hazard_stall), 64'd0);
    edge_step();

    // 2: ALU result walks through MEM, stage 2, WB, then leaves
    src_addr = {5'd0, 5'd8};
    push(8, 1, 1'b1);
    idle();
    settle(); chk("t2_sel_s1", 64'(fwd_sel[1:0]), 64'd1);
    chk("t2_stall", 64'(hazard_stall), 64'd0);
    edge_step();
    pipe_adv = 1'b1;
    settle(); edge_step();
    settle(); chk("t2_sel_s2", 64'(fwd_sel[1:0]), 64'd2); edge_step();
    settle(); chk("t2_sel_s3", 64'(fwd_sel[1:0]), 64'd3); edge_step();
    pipe_adv = 1'b0;
    settle(); chk("t2_sel_gone", 64'(fwd_sel[1:0]), 64'd0);
    chk("t2_hit_gone", 64'(fwd_hit[0]), 64'd0);
    edge_step();

    // 3: load-use, one bubble resolves it
    src_addr = {5'd9, 5'd0};
    push(9, 2, 1'b1);
    idle();
    settle(); chk("t3_stall", 64'(hazard_stall), 64'd1);
    chk("t3_sel1", 64'(fwd_sel[3:2]), 64'd0);
    pipe_adv = 1'b1;
    edge_step();
    pipe_adv = 1'b0;
    settle(); chk("t3_sel1_fwd", 64'(fwd_sel[3:2]), 64'd2);
    chk("t3_nostall", 64'(hazard_stall), 64'd0);
    edge_step();
    drain();

    // 4: younger load shadows older ALU producer of the same register
    src_addr = {5'd0, 5'd5};
    push(5, 1, 1'b1);
    push(5, 2, 1'b1);
    idle();
    settle(); chk("t4_stall", 64'(hazard_stall), 64'd1);
    chk("t4_sel0", 64'(fwd_sel[1:0]), 64'd0);
    pipe_adv = 1'b1;
    edge_step();
    pipe_adv = 1'b0;
    settle(); chk("t4_sel0_fwd", 64'(fwd_sel[1:0]), 64'd2);
    edge_step();
    drain();

    // 5: r0 never matches; unused operand reports hit but never stalls
    src_addr = {5'd0, 5'd0};
    push(0, 1, 1'b1);
    idle();
    settle(); chk("t5_r0_hit", 64'(fwd_hit[0]), 64'd0); edge_step();
    src_addr = {5'd0, 5'd7};
    src_used = 2'b00;
    push(7, 2, 1'b1);
    idle();
    settle(); chk("t5_unused_stall", 64'(hazard_stall), 64'd0);
    chk("t5_unused_hit", 64'(fwd_hit[0]), 64'd1);
    edge_step();
    drain();

    // 6: flush kills the load as it moves to stage 2
    src_addr = {5'd0, 5'd4};
    src_used = 2'b11;
    push(4, 2, 1'b1);
    idle();
    pipe_adv   = 1'b1;
    flush_mask = 3'b010;
    settle(); edge_step();
    idle();
    settle(); chk("t6_hit", 64'(fwd_hit[0]), 64'd0);
    chk("t6_stall", 64'(hazard_stall), 64'd0);
    edge_step();

    // held stall for three cycles (ready at WB, producer in MEM)
    src_addr = {5'd0, 5'd6};
    push(6, 3, 1'b1);
    idle();
    stall_base = pc_stall;
    repeat (3) begin settle(); chk("t6_held_stall", 64'(hazard_stall), 64'd1); edge_step(); end
`ifdef FWD_PERF_CNT_EN
    settle(); chk("t6_perf_stall3", 64'(perf_stall_cnt), 64'(stall_base + 32'd3)); edge_step();
`endif

    // reset mid-stall clears everything on the next cycle
    rst = 1'b1;
    settle(); edge_step();
    rst = 1'b0;
    settle(); chk("rst_mid_stall", 64'(hazard_stall), 64'd0);
    chk("rst_mid_hit", 64'(fwd_hit), 64'd0);
    edge_step();

    // random traffic on a small register range so matches are frequent
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 60) == 0);
      exe_valid    = $urandom_range(0, 3) != 0;
      exe_rfwr     = $urandom_range(0, 4) != 0;
      exe_dst      = AW'($urandom_range(0, 4));
      exe_ready_at = SW'($urandom_range(0, 3));
      pipe_adv     = $urandom_range(0, 2) != 0;
      flush_mask   = ($urandom_range(0, 7) == 0) ? NST'($urandom_range(1, 7)) : '0;
      src_addr     = {AW'($urandom_range(0, 4)), AW'($urandom_range(0, 4))};
      src_used     = NSRC'($urandom_range(0, 3));
      settle();
      edge_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
